// File: rtl/qoi_stream_encoder.sv
// QOI-style RGB332 frame encoder: pixel BRAM in, RUN/INDEX/DIFF/RAW bytes out.
// Ports: clk, rst (async high), start, rd_en/rd_addr/rd_data, wr_en/wr_addr/wr_data, busy, done, byte_count.
module qoi_stream_encoder #(
  parameter int NUM_PIXELS = 307200,
  parameter int ADDR_W     = 19,
  parameter int RD_LAT     = 1,
  parameter int MAX_RUN    = 62
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   byte_count
);

  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LW-1:0]     WLAST = LW'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] PLAST = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [5:0]        RMAX  = 6'(MAX_RUN);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_EVAL, S_EMIT, S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pcnt;
  logic [LW-1:0]     wcnt;
  logic [7:0]        pix;
  logic [7:0]        prev;
  logic [5:0]        run;
  logic [63:0]       idx_valid;
  logic [7:0]        idx [64];
  logic [7:0]        q1;
  logic [7:0]        q2;
  logic [1:0]        rem;
  logic              fin;

  logic [2:0] r, g, rp, gp, dr2, dg2;
  logic [1:0] b, bp, db2;
  logic [7:0] hsum;
  logic [5:0] h;
  logic       last;

  assign r    = pix[7:5];
  assign g    = pix[4:2];
  assign b    = pix[1:0];
  assign rp   = prev[7:5];
  assign gp   = prev[4:2];
  assign bp   = prev[1:0];
  assign hsum = 8'(r) * 8'd3 + 8'(g) * 8'd5 + 8'(b) * 8'd7;
  assign h    = hsum[5:0];
  assign last = (pcnt == PLAST);

  // Biased deltas: a delta of -2..+1 lands in 0..3, so bit 2 clear means it fits.
  assign dr2 = r - rp + 3'd2;
  assign dg2 = g - gp + 3'd2;
  assign db2 = b - bp + 2'd2;

  logic [5:0] rinc;
  logic [5:0] run_nxt;
  logic       upd;
  logic [1:0] nq;
  logic [1:0] opn;
  logic [7:0] op0, op1;
  logic [7:0] b0, b1, b2;

  always_comb begin
    rinc    = run + 6'd1;
    run_nxt = run;
    upd     = 1'b0;
    nq      = 2'd0;
    opn     = 2'd0;
    op0     = 8'h00;
    op1     = 8'h00;
    b0      = 8'h00;
    b1      = 8'h00;
    b2      = 8'h00;
    if (pix == prev) begin
      run_nxt = rinc;
      if (rinc == RMAX || last) begin
        b0      = {2'b11, rinc - 6'd1};
        nq      = 2'd1;
        run_nxt = 6'd0;
      end
    end else begin
      upd     = 1'b1;
      run_nxt = 6'd0;
      if (idx_valid[h] && idx[h] == pix) begin
        op0 = {2'b00, h};
        opn = 2'd1;
      end else if (!dr2[2] && !dg2[2]) begin
        op0 = {2'b01, dr2[1:0], dg2[1:0], db2};
        opn = 2'd1;
      end else begin
        op0 = 8'hFE;
        op1 = pix;
        opn = 2'd2;
      end
      if (run != 6'd0) begin
        b0 = {2'b11, run - 6'd1};
        b1 = op0;
        b2 = op1;
        nq = opn + 2'd1;
      end else begin
        b0 = op0;
        b1 = op1;
        nq = opn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_EVAL && upd) idx[h] <= pix;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pcnt       <= '0;
      wcnt       <= '0;
      pix        <= 8'h00;
      prev       <= 8'h00;
      run        <= 6'd0;
      idx_valid  <= 64'd0;
      q1         <= 8'h00;
      q2         <= 8'h00;
      rem        <= 2'd0;
      fin        <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      byte_count <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_FETCH;
            pcnt       <= '0;
            prev       <= 8'h00;
            run        <= 6'd0;
            idx_valid  <= 64'd0;
            byte_count <= '0;
            rd_en      <= 1'b1;
            rd_addr    <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        S_FETCH: begin
          rd_en <= 1'b0;
          wcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (wcnt == WLAST) begin
            pix   <= rd_data;
            state <= S_EVAL;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_EVAL: begin
          run <= run_nxt;
          fin <= last;
          if (upd) begin
            prev         <= pix;
            idx_valid[h] <= 1'b1;
          end
          if (!last) pcnt <= pcnt + 1'b1;
          if (nq != 2'd0) begin
            wr_en      <= 1'b1;
            wr_data    <= b0;
            wr_addr    <= byte_count;
            byte_count <= byte_count + 1'b1;
            q1         <= b1;
            q2         <= b2;
            rem        <= nq - 2'd1;
            state      <= S_EMIT;
          end else if (last) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state   <= S_FETCH;
            rd_en   <= 1'b1;
            rd_addr <= pcnt + 1'b1;
          end
        end
        S_EMIT: begin
          if (rem != 2'd0) begin
            wr_data    <= q1;
            q1         <= q2;
            wr_addr    <= byte_count;
            byte_count <= byte_count + 1'b1;
            rem        <= rem - 2'd1;
          end else begin
            wr_en <= 1'b0;
            if (fin) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state   <= S_FETCH;
              rd_en   <= 1'b1;
              rd_addr <= pcnt;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qoi_stream_encoder.sv
// Bench for qoi_stream_encoder: five parameter variants, table vectors,
// random frames against a queue-free reference encoder, reset/restart.
module tb_qoi_stream_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [4:0]          start;
  logic [4:0]          rd_en, wr_en, busy, done;
  logic [4:0][3:0]     rd_addr;
  logic [4:0][4:0]     wr_addr, byte_count;
  logic [4:0][7:0]     wr_data;
  logic [7:0]          mem [5][8];

  logic [12:0] cap [5][1024];
  int          cap_n [5] = '{default: 0};
  int          overlap = 0;

  int          vecs = 0;
  int          fails = 0;
  int          base;
  logic [7:0]  fr [8];
  logic [7:0]  exp_b [64];
  int          exp_n;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int NP = (g == 1) ? 3 : (g == 2) ? 2 : 8;
    localparam int RL = (g == 4) ? 3 : 1;
    localparam int MR = (g == 3) ? 4 : 62;
    logic [7:0] pd [RL];
    logic       pv [RL];
    logic [7:0] rdd;
    always @(posedge clk) begin
      pd[0] <= mem[g][rd_addr[g][2:0]];
      pv[0] <= rd_en[g];
      for (int i = 1; i < RL; i++) begin
        pd[i] <= pd[i-1];
        pv[i] <= pv[i-1];
      end
    end
    assign rdd = pv[RL-1] ? pd[RL-1] : 8'h5A;
    qoi_stream_encoder #(
      .NUM_PIXELS(NP), .ADDR_W(4), .RD_LAT(RL), .MAX_RUN(MR)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start[g]),
      .rd_en(rd_en[g]), .rd_addr(rd_addr[g]), .rd_data(rdd),
      .wr_en(wr_en[g]), .wr_addr(wr_addr[g]), .wr_data(wr_data[g]),
      .busy(busy[g]), .done(done[g]), .byte_count(byte_count[g])
    );
  end

  always @(negedge clk) begin
    for (int k = 0; k < 5; k++) begin
      if (rd_en[k] && wr_en[k]) overlap <= overlap + 1;
      if (wr_en[k] && cap_n[k] < 1024) begin
        cap[k][cap_n[k]] <= {wr_addr[k], wr_data[k]};
        cap_n[k] <= cap_n[k] + 1;
      end
    end
  end

  task automatic chk(input bit ok, input string nm, input int act, input int req);
    vecs++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, req);
    end
  endtask

  // Reference encoder working on whole pixels and integer channel math.
  function automatic void model(input int np, input int mr);
    int idxv [64];
    int prev, run, p, r, g, b, pr, pg, pb, h, dr, dg, db;
    for (int i = 0; i < 64; i++) idxv[i] = -1;
    prev  = 0;
    run   = 0;
    exp_n = 0;
    for (int i = 0; i < np; i++) begin
      p = int'(fr[i]);
      if (p == prev) begin
        run++;
        if (run == mr || i == np - 1) begin
          exp_b[exp_n++] = 8'(192 + run - 1);
          run = 0;
        end
        continue;
      end
      if (run > 0) begin
        exp_b[exp_n++] = 8'(192 + run - 1);
        run = 0;
      end
      r  = p / 32;     g  = (p / 4) % 8;     b  = p % 4;
      pr = prev / 32;  pg = (prev / 4) % 8;  pb = prev % 4;
      h  = (r * 3 + g * 5 + b * 7) % 64;
      dr = (r - pr + 8) % 8;
      dg = (g - pg + 8) % 8;
      db = (b - pb + 4) % 4;
      if (idxv[h] == p) begin
        exp_b[exp_n++] = 8'(h);
      end else if ((dr >= 6 || dr <= 1) && (dg >= 6 || dg <= 1)) begin
        exp_b[exp_n++] = 8'(64 + ((dr + 2) % 8) * 16 + ((dg + 2) % 8) * 4 + (db + 2) % 4);
      end else begin
        exp_b[exp_n++] = 8'hFE;
        exp_b[exp_n++] = 8'(p);
      end
      idxv[h] = p;
      prev    = p;
    end
  endfunction

  task automatic go(input int k, input int glitch,
                    output int tr0, output int tr1, output int tr2, output int twr);
    int cyc, nrd;
    base = cap_n[k];
    @(posedge clk); #1 start[k] = 1'b1;
    @(posedge clk); #1 start[k] = 1'b0;
    chk(busy[k] == 1'b1, "busy_after_start", int'(busy[k]), 1);
    chk(done[k] == 1'b0, "done_after_start", int'(done[k]), 0);
    cyc = 0; nrd = 0; tr0 = -1; tr1 = -1; tr2 = -1; twr = -1;
    while (!done[k] && cyc < 400) begin
      if (rd_en[k]) begin
        if (nrd == 0) tr0 = cyc;
        else if (nrd == 1) tr1 = cyc;
        else if (nrd == 2) tr2 = cyc;
        nrd++;
      end
      if (wr_en[k] && twr < 0) twr = cyc;
      @(posedge clk); #1;
      cyc++;
      start[k] = (cyc == glitch);
    end
    start[k] = 1'b0;
    chk(done[k] == 1'b1, "done_reached", int'(done[k]), 1);
    chk(busy[k] == 1'b0, "busy_in_done", int'(busy[k]), 0);
  endtask

  task automatic cmp(input int k, input string nm);
    int n;
    #2;
    n = cap_n[k] - base;
    chk(n == exp_n, {nm, "_len"}, n, exp_n);
    for (int i = 0; i < exp_n; i++) begin
      if (i < n)
        chk(cap[k][base+i] == {5'(i), exp_b[i]}, {nm, "_byte"},
            int'(cap[k][base+i]), int'({5'(i), exp_b[i]}));
    end
    chk(byte_count[k] == 5'(exp_n), {nm, "_byte_count"}, int'(byte_count[k]), exp_n);
  endtask

  task automatic gen(input int runny);
    logic [7:0] p;
    logic [7:0] pal [4];
    int m;
    pal[0] = 8'h80; pal[1] = 8'h24; pal[2] = 8'hE3; pal[3] = 8'h49;
    for (int i = 0; i < 8; i++) begin
      p = (i == 0) ? 8'h00 : fr[(i == 0) ? 0 : i - 1];
      m = int'($urandom_range(0, 3));
      if (runny != 0 && $urandom_range(0, 3) != 0) m = 0;
      case (m)
        0: fr[i] = p;
        1: fr[i] = p ^ (8'($urandom) & 8'h25);
        2: fr[i] = pal[$urandom_range(0, 3)];
        default: fr[i] = 8'($urandom);
      endcase
    end
  endtask

  typedef struct {
    int          k;
    logic [63:0] px;
    int          n;
    logic [31:0] ex;
  } vec_t;

  vec_t tbl [5];
  int   tr0, tr1, tr2, twr, nw;

  initial begin
    tbl[0] = '{k: 0, px: 64'h0000000000000000, n: 1, ex: 32'h000000C7};
    tbl[1] = '{k: 1, px: 64'h0000000000804080, n: 4, ex: 32'h0C4A80FE};
    tbl[2] = '{k: 2, px: 64'h0000000000002400, n: 2, ex: 32'h00007EC0};
    tbl[3] = '{k: 3, px: 64'h0000000000000000, n: 2, ex: 32'h0000C3C3};
    tbl[4] = '{k: 4, px: 64'h8080808080808080, n: 3, ex: 32'h00C680FE};

    rst   = 1'b1;
    start = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    chk({rd_en[0], wr_en[0], busy[0], done[0]} == 4'd0, "reset_ctrl",
        int'({rd_en[0], wr_en[0], busy[0], done[0]}), 0);
    chk(byte_count[0] == 5'd0, "reset_byte_count", int'(byte_count[0]), 0);
    chk({wr_addr[0], wr_data[0], rd_addr[0]} == 17'd0, "reset_addr_data",
        int'({wr_addr[0], wr_data[0], rd_addr[0]}), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 8; i++) mem[tbl[t].k][i] = tbl[t].px[8*i +: 8];
      exp_n = tbl[t].n;
      for (int i = 0; i < exp_n; i++) exp_b[i] = tbl[t].ex[8*i +: 8];
      go(tbl[t].k, 0, tr0, tr1, tr2, twr);
      cmp(tbl[t].k, "tbl");
      if (t == 4) begin
        chk(twr - tr0 == 5, "rdlat3_fetch_to_write", twr - tr0, 5);
        chk(tr1 - tr0 == 7, "rdlat3_raw_fetch_gap", tr1 - tr0, 7);
        chk(tr2 - tr1 == 5, "rdlat3_run_fetch_gap", tr2 - tr1, 5);
      end
    end

    for (int f = 0; f < 30; f++) begin
      gen(f % 3 == 0 ? 1 : 0);
      for (int i = 0; i < 8; i++) mem[0][i] = fr[i];
      model(8, 62);
      go(0, 0, tr0, tr1, tr2, twr);
      cmp(0, "rand_u0");
    end

    for (int f = 0; f < 10; f++) begin
      gen(1);
      for (int i = 0; i < 8; i++) mem[3][i] = fr[i];
      model(8, 4);
      go(3, 0, tr0, tr1, tr2, twr);
      cmp(3, "rand_run4");
    end

    for (int f = 0; f < 5; f++) begin
      gen(0);
      for (int i = 0; i < 8; i++) mem[4][i] = fr[i];
      model(8, 62);
      go(4, 0, tr0, tr1, tr2, twr);
      cmp(4, "rand_lat3");
    end

    fr[0] = 8'h80; fr[1] = 8'h81; fr[2] = 8'h81; fr[3] = 8'h07;
    fr[4] = 8'h07; fr[5] = 8'h07; fr[6] = 8'h80; fr[7] = 8'h24;
    for (int i = 0; i < 8; i++) mem[0][i] = fr[i];
    model(8, 62);
    @(posedge clk); #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    nw = 0;
    while (!(wr_en[0] && wr_addr[0] == 5'd1) && nw < 50) begin
      @(posedge clk); #1;
      nw++;
    end
    chk(wr_en[0] && wr_addr[0] == 5'd1, "reach_raw_second_byte", int'(wr_addr[0]), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk({rd_en[0], wr_en[0], busy[0], done[0]} == 4'd0, "midemit_reset_ctrl",
        int'({rd_en[0], wr_en[0], busy[0], done[0]}), 0);
    chk(byte_count[0] == 5'd0, "midemit_reset_count", int'(byte_count[0]), 0);
    chk({wr_addr[0], wr_data[0], rd_addr[0]} == 17'd0, "midemit_reset_addr_data",
        int'({wr_addr[0], wr_data[0], rd_addr[0]}), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    go(0, 3, tr0, tr1, tr2, twr);
    cmp(0, "after_reset");
    go(0, 0, tr0, tr1, tr2, twr);
    cmp(0, "restart_from_done");

    chk(overlap == 0, "rd_wr_overlap", overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
